mem_unlock_reader: RTL and testbench

Read-side initiator for the key-scrambled 1024x32 data memory. On `start` it drives the four-step unlock key sequence onto the memory's key input, then bursts `length` words out of the memory starting at `base_addr`. Each word is delivered on a valid/ready stream with a 2-entry output buffer, so downstream backpressure never loses data. It is the sole reader of the memory during a burst and never writes.

---
 rtl/mem_unlock_reader.sv | 151 +++++++++++++++
 tb/tb_mem_unlock_reader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_unlock_reader.sv
// Unlocks the scrambled data memory with a four-step key sequence, then bursts words out on a valid/ready stream.
// Output is registered two cycles after the address; a 2-entry buffer means a stalled consumer never loses a word.
module mem_unlock_reader #(
    parameter int KEY_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  base_addr,
    input  logic [10:0] length,
    output logic [9:0]  mem_address,
    output logic        mem_write,
    input  logic [31:0] mem_read_data,
    output logic [15:0] key_out,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, KEY, READ, DONE} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(KEY_HOLD - 1);

    state_t      state, state_nxt;
    logic [9:0]  base_q;
    logic [10:0] len_q;
    logic [10:0] len_clamped;
    logic [1:0]  step;
    logic [7:0]  hold;
    logic [10:0] issued;
    logic [10:0] popped;
    logic        in_flight;
    logic [9:0]  addr_q;
    logic [31:0] head;
    logic [31:0] tail;
    logic [1:0]  fill;
    logic        key_last;
    logic        pop;
    logic        issue;
    logic        last_pop;

    assign len_clamped = (length > 11'd1024) ? 11'd1024 : length;
    assign key_last    = (state == KEY) && (step == 2'd3) && (hold == HOLD_LAST);
    assign pop         = out_valid & out_ready;
    assign last_pop    = pop && (popped == len_q - 11'd1);

    // The word already in flight occupies a slot; a pop in the same cycle frees one.
    assign issue = (state == READ) && (issued != len_q) &&
                   (({1'b0, fill} + {2'b00, in_flight} - {2'b00, pop}) < 3'd2);

    assign mem_address = issue ? (base_q + issued[9:0]) : addr_q;
    assign mem_write   = 1'b0;
    assign out_data    = head;
    assign out_valid   = (fill != 2'd0);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = KEY;
            KEY:     if (key_last) state_nxt = (len_q == 11'd0) ? DONE : READ;
            READ:    if (last_pop) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        key_out = 16'h0000;
        if (state == KEY) begin
            case (step)
                2'd0:    key_out = 16'h0032;
                2'd1:    key_out = 16'h0087;
                2'd2:    key_out = 16'h1024;
                default: key_out = 16'h0324;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            len_q     <= '0;
            step      <= '0;
            hold      <= '0;
            issued    <= '0;
            popped    <= '0;
            in_flight <= 1'b0;
            addr_q    <= '0;
            head      <= '0;
            tail      <= '0;
            fill      <= '0;
        end else begin
            if (state == IDLE && start) begin
                base_q <= base_addr;
                len_q  <= len_clamped;
                step   <= '0;
                hold   <= '0;
                issued <= '0;
                popped <= '0;
            end
            if (state == KEY) begin
                if (hold == HOLD_LAST) begin
                    hold <= '0;
                    step <= step + 2'd1;
                end else begin
                    hold <= hold + 8'd1;
                end
            end
            if (issue) begin
                issued <= issued + 11'd1;
                addr_q <= mem_address;
            end
            in_flight <= issue;
            if (pop) begin
                popped <= popped + 11'd1;
            end
            // Memory data arrives the cycle after its address and is pushed behind any buffered word.
            case ({in_flight, pop})
                2'b10: begin
                    if (fill == 2'd0) head <= mem_read_data;
                    else              tail <= mem_read_data;
                    fill <= fill + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    fill <= fill - 2'd1;
                end
                2'b11: begin
                    if (fill == 2'd1) begin
                        head <= mem_read_data;
                    end else begin
                        head <= tail;
                        tail <= mem_read_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_unlock_reader.sv
// Randomized bench for mem_unlock_reader: memory model plus a per-burst queue of expected words.
module tb_mem_unlock_reader;
    localparam int KH     = 4;
    localparam int KEYCYC = 4 * KH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] length = '0;
    logic        out_ready = 1'b0;
    logic [9:0]  mem_address;
    logic        mem_write;
    logic [31:0] mem_read_data;
    logic [15:0] key_out;
    logic [31:0] out_data;
    logic        out_valid;
    logic        busy;
    logic        done;

    logic [31:0] mem [1024];
    logic [15:0] keys [4];
    int          checks = 0;
    int          errors = 0;

    mem_unlock_reader #(.KEY_HOLD(KH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .mem_address   (mem_address),
        .mem_write     (mem_write),
        .mem_read_data (mem_read_data),
        .key_out       (key_out),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_read_data <= mem[mem_address];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"},  32'(mem_address), 32'd0);
        chk({tag, "_write"}, 32'(mem_write),   32'd0);
        chk({tag, "_key"},   32'(key_out),     32'd0);
        chk({tag, "_data"},  out_data,         32'd0);
        chk({tag, "_valid"}, 32'(out_valid),   32'd0);
        chk({tag, "_busy"},  32'(busy),        32'd0);
        chk({tag, "_done"},  32'(done),        32'd0);
    endtask

    // mode 0: ready always high; 1: ready pattern 1-0-0-1; 2: random ready and stray start pulses.
    // stop_pops > 0 returns right after that many pops, leaving the burst in progress.
    task automatic run_burst(input logic [9:0] b, input logic [10:0] l, input int mode, input int stop_pops);
        int          n;
        int          c;
        int          pops;
        int          last_pop_c;
        int          limit;
        logic        prev_stall;
        logic        finished;
        logic [31:0] prev_data;
        logic [9:0]  ea;
        logic [31:0] exp_q [$];

        n = (l > 11'd1024) ? 1024 : int'(l);
        for (int i = 0; i < n; i++) exp_q.push_back(mem[(int'(b) + i) % 1024]);
        pops = 0; last_pop_c = 0; prev_stall = 1'b0; prev_data = '0; finished = 1'b0;
        limit = KEYCYC + 4 * n + 40;

        @(negedge clk);
        start = 1'b1; base_addr = b; length = l; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; base_addr = 10'($urandom); length = 11'($urandom);
        c = 1;
        while (!finished && c <= limit) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((c % 4) == 0) || ((c % 4) == 3);
                default: begin
                    out_ready = 1'($urandom_range(0, 1));
                    start     = 1'($urandom_range(0, 1));
                end
            endcase
            #1;
            if (c <= KEYCYC) chk("key", 32'(key_out), 32'(keys[(c - 1) / KH]));
            else if (c == KEYCYC + 1) chk("key_off", 32'(key_out), 32'd0);
            if (c == 1) chk("busy_on", 32'(busy), 32'd1);
            chk("mem_write", 32'(mem_write), 32'd0);
            if (mode == 0 && c > KEYCYC && c <= KEYCYC + 4 && (c - KEYCYC) <= n) begin
                ea = 10'(int'(b) + c - KEYCYC - 1);
                chk("addr", 32'(mem_address), 32'(ea));
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_word", 32'd1, 32'd0);
                else chk("data", out_data, exp_q.pop_front());
                if (mode == 0) chk("pop_cycle", 32'(c), 32'(KEYCYC + 3 + pops));
                pops++;
                last_pop_c = c;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (stop_pops > 0 && pops == stop_pops) return;
            if (done) begin
                chk("done_cycle", 32'(c), (n == 0) ? 32'(KEYCYC + 1) : 32'(last_pop_c + 1));
                chk("word_count", 32'(pops), 32'(n));
                finished = 1'b1;
            end
            @(negedge clk);
            c++;
        end
        if (!finished) begin
            chk("timeout", 32'd0, 32'd1);
        end else begin
            start = 1'b0;
            #1;
            chk("done_pulse", 32'(done), 32'd0);
            chk("busy_off", 32'(busy), 32'd0);
            chk("idle_valid", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        keys[0] = 16'h0032;
        keys[1] = 16'h0087;
        keys[2] = 16'h1024;
        keys[3] = 16'h0324;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk_reset_vals("rst");

        run_burst(10'h3FE, 11'd4, 0, 0);
        run_burst(10'($urandom), 11'd8, 1, 0);
        run_burst(10'($urandom), 11'd0, 0, 0);
        run_burst(10'($urandom), 11'd2047, 2, 0);
        for (int k = 0; k < 6; k++) run_burst(10'($urandom), 11'($urandom_range(1, 40)), 2, 0);

        run_burst(10'h3F0, 11'd20, 0, 3);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_burst(10'h3F0, 11'd20, 2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
